// File: rtl/alu_2bit_pkg.sv
// Shared opcodes, mode constants and arithmetic operand decode for the 74181-style ALU.
// Used by alu_2bit_core and alu_2bit (optional ALU_AEQB_EN lives in those files).
package alu_2bit_pkg;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  // Arithmetic-mode opcodes (m = 0)
  localparam logic [3:0] OP_ARITH_A            = 4'b0000;
  localparam logic [3:0] OP_ARITH_A_OR_B       = 4'b0001;
  localparam logic [3:0] OP_ARITH_A_OR_NB      = 4'b0010;
  localparam logic [3:0] OP_ARITH_MINUS1       = 4'b0011;
  localparam logic [3:0] OP_ARITH_A_P_ANB      = 4'b0100;
  localparam logic [3:0] OP_ARITH_AOB_P_ANB    = 4'b0101;
  localparam logic [3:0] OP_SUB                = 4'b0110;
  localparam logic [3:0] OP_ARITH_ANB_M1       = 4'b0111;
  localparam logic [3:0] OP_ARITH_A_P_AB       = 4'b1000;
  localparam logic [3:0] OP_ADD                = 4'b1001;
  localparam logic [3:0] OP_ARITH_AONB_P_AB    = 4'b1010;
  localparam logic [3:0] OP_ARITH_AB_M1        = 4'b1011;
  localparam logic [3:0] OP_ARITH_DOUBLE       = 4'b1100;
  localparam logic [3:0] OP_ARITH_AOB_P_A      = 4'b1101;
  localparam logic [3:0] OP_ARITH_AONB_P_A     = 4'b1110;
  localparam logic [3:0] OP_ARITH_DEC          = 4'b1111;

  // Logic-mode opcodes (m = 1)
  localparam logic [3:0] OP_NOT_A   = 4'b0000;
  localparam logic [3:0] OP_NOR     = 4'b0001;
  localparam logic [3:0] OP_NA_AND_B = 4'b0010;
  localparam logic [3:0] OP_ZERO    = 4'b0011;
  localparam logic [3:0] OP_NAND    = 4'b0100;
  localparam logic [3:0] OP_NOT_B   = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_A_AND_NB = 4'b0111;
  localparam logic [3:0] OP_NA_OR_B = 4'b1000;
  localparam logic [3:0] OP_XNOR    = 4'b1001;
  localparam logic [3:0] OP_PASS_B  = 4'b1010;
  localparam logic [3:0] OP_AND     = 4'b1011;
  localparam logic [3:0] OP_ONES    = 4'b1100;
  localparam logic [3:0] OP_A_OR_NB = 4'b1101;
  localparam logic [3:0] OP_OR      = 4'b1110;
  localparam logic [3:0] OP_PASS_A  = 4'b1111;

  typedef enum logic [2:0] {
    XSelA,
    XSelAOrB,
    XSelAOrNb,
    XSelOnes,
    XSelAAndNb,
    XSelAAndB
  } x_sel_e;

  typedef enum logic [2:0] {
    YSelZero,
    YSelAAndNb,
    YSelNb,
    YSelOnes,
    YSelAAndB,
    YSelB,
    YSelA
  } y_sel_e;

  typedef struct packed {
    x_sel_e x;
    y_sel_e y;
  } arith_sel_t;

  // Map an arithmetic opcode to the pair of adder operands, sum = X + Y + cin.
  function automatic arith_sel_t decode_arith(input logic [3:0] s);
    arith_sel_t sel;
    sel.x = XSelA;
    sel.y = YSelZero;
    case (s)
      OP_ARITH_A:         begin sel.x = XSelA;      sel.y = YSelZero;   end
      OP_ARITH_A_OR_B:    begin sel.x = XSelAOrB;   sel.y = YSelZero;   end
      OP_ARITH_A_OR_NB:   begin sel.x = XSelAOrNb;  sel.y = YSelZero;   end
      OP_ARITH_MINUS1:    begin sel.x = XSelOnes;   sel.y = YSelZero;   end
      OP_ARITH_A_P_ANB:   begin sel.x = XSelA;      sel.y = YSelAAndNb; end
      OP_ARITH_AOB_P_ANB: begin sel.x = XSelAOrB;   sel.y = YSelAAndNb; end
      OP_SUB:             begin sel.x = XSelA;      sel.y = YSelNb;     end
      OP_ARITH_ANB_M1:    begin sel.x = XSelAAndNb; sel.y = YSelOnes;   end
      OP_ARITH_A_P_AB:    begin sel.x = XSelA;      sel.y = YSelAAndB;  end
      OP_ADD:             begin sel.x = XSelA;      sel.y = YSelB;      end
      OP_ARITH_AONB_P_AB: begin sel.x = XSelAOrNb;  sel.y = YSelAAndB;  end
      OP_ARITH_AB_M1:     begin sel.x = XSelAAndB;  sel.y = YSelOnes;   end
      OP_ARITH_DOUBLE:    begin sel.x = XSelA;      sel.y = YSelA;      end
      OP_ARITH_AOB_P_A:   begin sel.x = XSelAOrB;   sel.y = YSelA;      end
      OP_ARITH_AONB_P_A:  begin sel.x = XSelAOrNb;  sel.y = YSelA;      end
      OP_ARITH_DEC:       begin sel.x = XSelA;      sel.y = YSelOnes;   end
      default:            begin sel.x = XSelA;      sel.y = YSelZero;   end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_2bit_core.sv
// Combinational 74181-style function core: next f/cout from a, b, s, m, cin.
// With ALU_AEQB_EN defined it also produces the all-ones (A=B) flag.
module alu_2bit_core
  import alu_2bit_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             cin_i,
`ifdef ALU_AEQB_EN
  output logic             aeqb_o,
`endif
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o
);

  localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};

  arith_sel_t       sel;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] x_op;
  logic [WIDTH-1:0] y_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_f;

  assign nb  = ~b_i;
  assign sel = decode_arith(s_i);

  always_comb begin
    x_op = a_i;
    case (sel.x)
      XSelA:      x_op = a_i;
      XSelAOrB:   x_op = a_i | b_i;
      XSelAOrNb:  x_op = a_i | nb;
      XSelOnes:   x_op = Ones;
      XSelAAndNb: x_op = a_i & nb;
      XSelAAndB:  x_op = a_i & b_i;
      default:    x_op = a_i;
    endcase
  end

  always_comb begin
    y_op = '0;
    case (sel.y)
      YSelZero:   y_op = '0;
      YSelAAndNb: y_op = a_i & nb;
      YSelNb:     y_op = nb;
      YSelOnes:   y_op = Ones;
      YSelAAndB:  y_op = a_i & b_i;
      YSelB:      y_op = b_i;
      YSelA:      y_op = a_i;
      default:    y_op = '0;
    endcase
  end

  // One extra bit so the carry out of the MSB falls into sum[WIDTH].
  assign sum = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin_i};

  always_comb begin
    logic_f = '0;
    case (s_i)
      OP_NOT_A:    logic_f = ~a_i;
      OP_NOR:      logic_f = ~(a_i | b_i);
      OP_NA_AND_B: logic_f = ~a_i & b_i;
      OP_ZERO:     logic_f = '0;
      OP_NAND:     logic_f = ~(a_i & b_i);
      OP_NOT_B:    logic_f = nb;
      OP_XOR:      logic_f = a_i ^ b_i;
      OP_A_AND_NB: logic_f = a_i & nb;
      OP_NA_OR_B:  logic_f = ~a_i | b_i;
      OP_XNOR:     logic_f = ~(a_i ^ b_i);
      OP_PASS_B:   logic_f = b_i;
      OP_AND:      logic_f = a_i & b_i;
      OP_ONES:     logic_f = Ones;
      OP_A_OR_NB:  logic_f = a_i | nb;
      OP_OR:       logic_f = a_i | b_i;
      OP_PASS_A:   logic_f = a_i;
      default:     logic_f = '0;
    endcase
  end

  always_comb begin
    f_o    = sum[WIDTH-1:0];
    cout_o = sum[WIDTH];
    if (m_i == MODE_LOGIC) begin
      f_o    = logic_f;
      cout_o = 1'b0;
    end
  end

`ifdef ALU_AEQB_EN
  assign aeqb_o = &f_o;
`endif

endmodule

// File: rtl/alu_2bit.sv
// Registered 74181-style ALU slice: core result captured every clock, one-cycle latency.
// Optional ALU_AEQB_EN adds the registered all-ones flag output aeqb.
module alu_2bit
  import alu_2bit_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
`ifdef ALU_AEQB_EN
  output logic             aeqb,
`endif
  output logic [WIDTH-1:0] f,
  output logic             cout
);

  logic [WIDTH-1:0] f_d, f_q;
  logic             cout_d, cout_q;

`ifdef ALU_AEQB_EN
  logic aeqb_d, aeqb_q;
`endif

  alu_2bit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i    (a),
    .b_i    (b),
    .s_i    (s),
    .m_i    (m),
    .cin_i  (cin),
`ifdef ALU_AEQB_EN
    .aeqb_o (aeqb_d),
`endif
    .f_o    (f_d),
    .cout_o (cout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      f_q    <= f_d;
      cout_q <= cout_d;
    end
  end

`ifdef ALU_AEQB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aeqb_q <= 1'b0;
    end else begin
      aeqb_q <= aeqb_d;
    end
  end

  assign aeqb = aeqb_q;
`endif

  assign f    = f_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_alu_2bit.sv
// Self-checking bench for alu_2bit: directed steps plus random operations against a
// truth-table / operand-table reference model.
module tb_alu_2bit;

  localparam int W    = 2;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic [3:0]   s;
  logic         m, cin;
  logic [W-1:0] f;
  logic         cout;
`ifdef ALU_AEQB_EN
  logic         aeqb;
`endif

  int total = 0;
  int bad   = 0;

  // Logic mode: bit k of f is lut[s][{a[k], b[k]}].
  logic [3:0] lut [16] = '{4'b0011, 4'b0001, 4'b0010, 4'b0000,
                           4'b0111, 4'b0101, 4'b0110, 4'b0100,
                           4'b1011, 4'b1001, 4'b1010, 4'b1000,
                           4'b1111, 4'b1101, 4'b1110, 4'b1100};
  // Arithmetic mode: X index into {A, A|B, A|~B, ONES, A&~B, A&B},
  // Y index into {0, A&~B, ~B, ONES, A&B, B, A}.
  int xsel [16] = '{0, 1, 2, 3, 0, 1, 0, 4, 0, 0, 2, 5, 0, 1, 2, 0};
  int ysel [16] = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 5, 4, 3, 6, 6, 6, 3};

  alu_2bit #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .s     (s),
    .m     (m),
    .cin   (cin),
`ifdef ALU_AEQB_EN
    .aeqb  (aeqb),
`endif
    .f     (f),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic model(input int ta, input int tb, input int ts, input int tm, input int tc,
                       output int ef, output int ec);
    int xv [6];
    int yv [7];
    int nb;
    int tot;
    logic [3:0] row;
    ef = 0;
    ec = 0;
    if (tm == 1) begin
      row = lut[ts];
      for (int k = 0; k < W; k++) begin
        if (row[((ta >> k) & 1) * 2 + ((tb >> k) & 1)]) ef = ef | (1 << k);
      end
    end else begin
      nb = ~tb & MASK;
      xv = '{ta, ta | tb, ta | nb, MASK, ta & nb, ta & tb};
      yv = '{0, ta & nb, nb, MASK, ta & tb, tb, ta};
      tot = xv[xsel[ts]] + yv[ysel[ts]] + tc;
      ef = tot % (MASK + 1);
      ec = tot / (MASK + 1);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input int ta, input int tb, input int ts, input int tm, input int tc);
    @(negedge clk);
    a   = W'(ta);
    b   = W'(tb);
    s   = 4'(ts);
    m   = tm[0];
    cin = tc[0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag, input int ta, input int tb, input int ts,
                             input int tm, input int tc);
    int ef, ec;
    model(ta, tb, ts, tm, tc, ef, ec);
    check({tag, "_f"}, int'(f), ef);
    check({tag, "_cout"}, int'(cout), ec);
`ifdef ALU_AEQB_EN
    check({tag, "_aeqb"}, int'(aeqb), (ef == MASK) ? 1 : 0);
`endif
  endtask

  initial begin
    int ra, rb, rs, rm, rc;
    rst_n = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    #2;
    check("reset_f", int'(f), 0);
    check("reset_cout", int'(cout), 0);
`ifdef ALU_AEQB_EN
    check("reset_aeqb", int'(aeqb), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // m=0, cin=1, a=01, b=10
    apply(1, 2, 4'b0110, 0, 1);
    check("sub_f", int'(f), 3);
    check("sub_cout", int'(cout), 0);
    apply(1, 2, 4'b0000, 0, 1);
    check("a_inc_f", int'(f), 2);
    check("a_inc_cout", int'(cout), 0);
    apply(1, 2, 4'b1111, 0, 1);
    check("dec_f", int'(f), 1);
    check("dec_cout", int'(cout), 1);

    // Asynchronous reset mid-operation, well before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_f", int'(f), 0);
    check("async_rst_cout", int'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 2, 4'b1001, 0, 1);
    check("add_f", int'(f), 0);
    check("add_cout", int'(cout), 1);

    // Logic mode, cin held high to show it is ignored.
    apply(1, 2, 4'b0110, 1, 1);
    check("xor_f", int'(f), 3);
    check("xor_cout", int'(cout), 0);
    apply(1, 2, 4'b1011, 1, 1);
    check("and_f", int'(f), 0);
    check("and_cout", int'(cout), 0);
    apply(1, 2, 4'b1110, 1, 1);
    check("or_f", int'(f), 3);
    check("or_cout", int'(cout), 0);
    apply(1, 2, 4'b0000, 1, 1);
    check("nota_f", int'(f), 2);
    check("nota_cout", int'(cout), 0);

    // Inputs changing between edges must not reach the outputs.
    #1;
    a = 2'b11; b = 2'b11; s = 4'b1100; m = 1'b0; cin = 1'b1;
    #2;
    check("hold_f", int'(f), 2);
    check("hold_cout", int'(cout), 0);

    // Sweep every arithmetic select with 10-cycle spacing.
    for (int i = 0; i < 16; i++) begin
      apply(1, 2, i, 0, 1);
      check_model($sformatf("sweep_s%0d", i), 1, 2, i, 0, 1);
      repeat (9) @(posedge clk);
    end

`ifdef ALU_AEQB_EN
    apply(2, 2, 4'b0110, 0, 0);
    check("aeqb_eq_f", int'(f), 3);
    check("aeqb_eq", int'(aeqb), 1);
    apply(1, 2, 4'b0110, 0, 0);
    check("aeqb_ne", int'(aeqb), 0);
`endif

    for (int n = 0; n < 300; n++) begin
      ra = int'($urandom_range(MASK, 0));
      rb = int'($urandom_range(MASK, 0));
      rs = int'($urandom_range(15, 0));
      rm = int'($urandom_range(1, 0));
      rc = int'($urandom_range(1, 0));
      apply(ra, rb, rs, rm, rc);
      check_model($sformatf("rand%0d_m%0d_s%0d_a%0d_b%0d_c%0d", n, rm, rs, ra, rb, rc),
                  ra, rb, rs, rm, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_2bit.md
Name: alu_2bit

Overview:
- 74181-style ALU, WIDTH bits wide (default 2), with a registered output stage.
- 4-bit select s and mode m choose one of 16 logic functions (m=1) or 16 arithmetic functions with carry (m=0).
- Combinational core feeds output flops; one-cycle latency.
- Used as a datapath slice in the reversible-gate ALU exploration; cascadable through cin/cout.

Parameters:
- WIDTH, 2, operand/result width in bits (legal values 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  function select.
- m  input  1  mode: 1 = logic, 0 = arithmetic.
- cin  input  1  carry-in, active-high (adds +1).
- f  output  WIDTH  registered result.
- cout  output  1  registered carry-out, active-high.

Behaviour:
- Reset: rst_n=0 clears f=0 and cout=0 immediately (asynchronous). Release is synchronous to the next clk edge.
- Every rising clk edge (rst_n=1): f/cout <= combinational result of current a,b,s,m,cin. Latency is 1 cycle; no handshake; a new operation every cycle.
- Logic mode (m=1), by s:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 all zeros
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B
  - 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A
  - cin is ignored; cout=0.
- Arithmetic mode (m=0): sum = X + Y + cin, computed at WIDTH+1 bits. f = sum[WIDTH-1:0], cout = sum[WIDTH]. ONES = all-ones vector. X,Y by s:
  - 0000 A,0; 0001 A|B,0; 0010 A|~B,0; 0011 ONES,0
  - 0100 A,A&~B; 0101 A|B,A&~B; 0110 A,~B (A-B-1+cin); 0111 A&~B,ONES
  - 1000 A,A&B; 1001 A,B; 1010 A|~B,A&B; 1011 A&B,ONES
  - 1100 A,A; 1101 A|B,A; 1110 A|~B,A; 1111 A,ONES
- Wrap-around: results are modulo 2^WIDTH; overflow is visible only via cout.
- Subtract (s=0110, cin=1): cout=1 means no borrow (A>=B).
- Inputs changing between edges have no effect until the next edge.
- X/Z on inputs is not sanitized.

Optional Feature:
- Macro ALU_AEQB_EN.
- Defined: adds output port aeqb (1 bit), registered alongside f. Set to 1 when the combinational f is all ones in either mode (74181 A=B comparator usage with s=0110, m=0, cin=0). Reset value 0.
- Undefined: port and flop absent; all other behaviour is identical.

Decomposition:
- Package alu_2bit_pkg holds localparams for the s opcodes (e.g. OP_ADD=4'b1001, OP_SUB=4'b0110, OP_XOR=4'b0110 in logic mode) and the mode constants MODE_LOGIC=1'b1, MODE_ARITH=1'b0.
- One sub-module, alu_2bit_core: purely combinational, producing the next f/cout (and aeqb when enabled).
- The top level instantiates the core and holds the registers.

Test Plan:
- Reset: drive rst_n=0 mid-operation -> f=00 and cout=0 immediately, without a clock edge. Release and clock with a=01, b=10, m=0, s=1001, cin=1 -> next edge gives f=00, cout=1 (1+2+1=4).
- m=0, cin=1, a=01, b=10:
  - s=0110 -> f=11, cout=0 (1-2 borrow).
  - s=0000 -> f=10, cout=0.
  - s=1111 -> f=01, cout=1.
- m=1, a=01, b=10: s=0110 -> f=11; s=1011 -> f=00; s=1110 -> f=11; s=0000 -> f=10; cout=0 throughout.
- Sweep all i/j loops over 16 s codes with a=01, b=10, m=0, cin=1, 10-cycle spacing -> each f/cout matches the X+Y+cin model one cycle after the stimulus.
- ALU_AEQB_EN: a=b=10, m=0, s=0110, cin=0 -> f=11, aeqb=1. With a=01, b=10 -> aeqb=0.
